// File: rtl/i2c_reg_bank.sv
// Register bank behind an I2C slave: pointer byte then write data, or
// sequential reads. The last index is a read-only status byte.
//
// state   | meaning
// S_IDLE  | not addressed; data strobes ignored
// S_PTR   | addressed for write, next byte loads ptr
// S_WRITE | bytes written to reg[ptr], ptr auto-increments
// S_READ  | i2c_data_tx offered, ptr advances on each load
module i2c_reg_bank #(
  parameter int         NUM_REGS    = 16,
  parameter logic [6:0] I2C_ADDRESS = 7'h42,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              i2c_addr_rw,
  input  logic                    i2c_addr_rw_valid_stb,
  input  logic [7:0]              i2c_data_rx,
  input  logic                    i2c_data_rx_valid_stb,
  output logic [7:0]              i2c_data_tx,
  input  logic                    i2c_data_tx_loaded_stb,
  input  logic                    i2c_error_stb,
  output logic                    stall,
  output logic [8*NUM_REGS-1:0]   regs_flat,
  input  logic [7:0]              ro_status,
  output logic                    wr_stb,
  output logic [PW-1:0]           wr_addr,
  output logic [7:0]              wr_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PTR   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(NUM_REGS - 1);

  state_t                     state_q, state_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;
  logic [7:0]                 data_tx_q, data_tx_d;
  logic                       stall_q, stall_d;
  logic                       wr_stb_q, wr_stb_d;
  logic [PW-1:0]              wr_addr_q, wr_addr_d;
  logic [7:0]                 wr_data_q, wr_data_d;

  logic addr_match;
  logic wr_en;
  logic ptr_upd;

  assign addr_match = (i2c_addr_rw[7:1] == I2C_ADDRESS);

  // Address strobe beats error, error beats data/load strobes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    ptr_upd = 1'b0;
    if (i2c_addr_rw_valid_stb) begin
      if (!addr_match)         state_d = S_IDLE;
      else if (i2c_addr_rw[0]) state_d = S_READ;
      else                     state_d = S_PTR;
    end else if (i2c_error_stb) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_PTR: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_d   = i2c_data_rx[PW-1:0];
            ptr_upd = 1'b1;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (i2c_data_rx_valid_stb) begin
            wr_en   = (ptr_q != LAST);
            ptr_d   = ptr_q + PW'(1);
            ptr_upd = 1'b1;
          end
        end
        S_READ: begin
          if (i2c_data_tx_loaded_stb) begin
            ptr_d   = ptr_q + PW'(1);
            ptr_upd = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    regs_d    = regs_q;
    wr_stb_d  = wr_en;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en) begin
      regs_d[ptr_q] = i2c_data_rx;
      wr_addr_d     = ptr_q;
      wr_data_d     = i2c_data_rx;
    end
  end

  // tx lags ptr/register changes by one cycle; stall covers exactly that cycle.
  always_comb begin
    data_tx_d = (ptr_q == LAST) ? ro_status : regs_q[ptr_q];
    stall_d   = ptr_upd | wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      regs_q    <= '0;
      data_tx_q <= 8'h00;
      stall_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      regs_q    <= regs_d;
      data_tx_q <= data_tx_d;
      stall_q   <= stall_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign i2c_data_tx = data_tx_q;
  assign stall       = stall_q;
  assign regs_flat   = regs_q;
  assign wr_stb      = wr_stb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: expected writes and reads are queued as
// stimulus is issued; a negedge monitor pops and compares.
module tb_i2c_reg_bank;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   i2c_addr_rw = 8'h00;
  logic         i2c_addr_rw_valid_stb = 1'b0;
  logic [7:0]   i2c_data_rx = 8'h00;
  logic         i2c_data_rx_valid_stb = 1'b0;
  logic [7:0]   i2c_data_tx;
  logic         i2c_data_tx_loaded_stb = 1'b0;
  logic         i2c_error_stb = 1'b0;
  logic         stall;
  logic [8*N-1:0] regs_flat;
  logic [7:0]   ro_status = 8'h5A;
  logic         wr_stb;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;

  i2c_reg_bank #(.NUM_REGS(N), .I2C_ADDRESS(7'h42)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i2c_addr_rw            (i2c_addr_rw),
    .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
    .i2c_data_rx            (i2c_data_rx),
    .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
    .i2c_data_tx            (i2c_data_tx),
    .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
    .i2c_error_stb          (i2c_error_stb),
    .stall                  (stall),
    .regs_flat              (regs_flat),
    .ro_status              (ro_status),
    .wr_stb                 (wr_stb),
    .wr_addr                (wr_addr),
    .wr_data                (wr_data)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [11:0] wrq[$];
  logic [7:0]  rdq[$];
  logic [7:0]  exp_regs [N];
  logic        rd_chk = 1'b0;
  logic [11:0] wr_e;
  logic [7:0]  rd_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [7:0] b);
    cyc();
    i2c_addr_rw = b;
    i2c_addr_rw_valid_stb = 1'b1;
    cyc();
    i2c_addr_rw_valid_stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    cyc();
    i2c_data_rx = b;
    i2c_data_rx_valid_stb = 1'b1;
    cyc();
    i2c_data_rx_valid_stb = 1'b0;
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
    wrq.push_back({a, d});
    exp_regs[a] = d;
  endtask

  task automatic check_regs(input string nm);
    for (int k = 0; k < N; k++)
      check($sformatf("%s_reg%0d", nm, k), 32'(regs_flat[8*k +: 8]), 32'(exp_regs[k]));
  endtask

  // Slave-side read: wait out stall, capture, then confirm stall covers the ptr step.
  task automatic rd(input logic [7:0] e);
    int n;
    rdq.push_back(e);
    n = 0;
    while (stall && n < 20) begin
      cyc();
      n++;
    end
    if (stall) begin
      vecs++;
      errs++;
      $display("FAIL rd_stall_timeout: stall still 1 after %0d cycles, required 0", n);
    end
    rd_chk = 1'b1;
    i2c_data_tx_loaded_stb = 1'b1;
    cyc();
    i2c_data_tx_loaded_stb = 1'b0;
    rd_chk = 1'b0;
    check("stall_after_ptr", 32'(stall), 32'd1);
    cyc();
    check("stall_release", 32'(stall), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (wrq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL wr_unexpected: got addr %0d data %0h, required no pulse", wr_addr, wr_data);
      end else begin
        wr_e = wrq.pop_front();
        check("wr_pulse", 32'({wr_addr, wr_data}), 32'(wr_e));
      end
    end
    if (rst_n && rd_chk && i2c_data_tx_loaded_stb) begin
      if (rdq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rd_unexpected: got tx %0h with no expectation", i2c_data_tx);
      end else begin
        rd_e = rdq.pop_front();
        check("rd_data", 32'(i2c_data_tx), 32'(rd_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) exp_regs[k] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    check("reset_tx", 32'(i2c_data_tx), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_wr_stb", 32'(wr_stb), 32'h0);
    check("reset_wr_addr", 32'(wr_addr), 32'h0);
    check("reset_wr_data", 32'(wr_data), 32'h0);
    rst_n = 1'b1;
    cyc();

    // Pointer 3, then two sequential writes.
    send_addr(8'h84);
    send_rx(8'h03);
    exp_wr(4'd3, 8'hAA);
    send_rx(8'hAA);
    exp_wr(4'd4, 8'h55);
    send_rx(8'h55);
    cyc();
    cyc();
    check_regs("wr34");

    // Repeated-start read back from index 3.
    send_addr(8'h84);
    send_rx(8'h03);
    check("stall_ptr_load", 32'(stall), 32'd1);
    send_addr(8'h85);
    rd(8'hAA);
    rd(8'h55);

    // Write across the read-only slot and wrap to 0.
    send_addr(8'h84);
    send_rx(8'h0E);
    exp_wr(4'd14, 8'h11);
    send_rx(8'h11);
    send_rx(8'h22);
    exp_wr(4'd0, 8'h33);
    send_rx(8'h33);
    cyc();
    cyc();
    check_regs("wrap");
    send_addr(8'h84);
    send_rx(8'h0F);
    send_addr(8'h85);
    rd(8'h5A);
    rd(8'h33);

    // Foreign address: everything that follows is ignored.
    send_addr(8'h86);
    repeat (3) begin
      send_rx(8'hFF);
      check("stall_foreign", 32'(stall), 32'd0);
    end
    cyc();
    i2c_data_tx_loaded_stb = 1'b1;
    cyc();
    i2c_data_tx_loaded_stb = 1'b0;
    check("loaded_idle_stall", 32'(stall), 32'd0);
    check_regs("foreign");

    // Error coinciding with a write data byte.
    send_addr(8'h84);
    send_rx(8'h02);
    cyc();
    i2c_data_rx = 8'h77;
    i2c_data_rx_valid_stb = 1'b1;
    i2c_error_stb = 1'b1;
    cyc();
    i2c_data_rx_valid_stb = 1'b0;
    i2c_error_stb = 1'b0;
    check("err_stall", 32'(stall), 32'd0);
    send_rx(8'h88);
    check("err_idle_stall", 32'(stall), 32'd0);
    check_regs("err");

    // Reset landing on a write byte.
    send_addr(8'h84);
    send_rx(8'h06);
    cyc();
    i2c_data_rx = 8'h99;
    i2c_data_rx_valid_stb = 1'b1;
    #1 rst_n = 1'b0;
    cyc();
    i2c_data_rx_valid_stb = 1'b0;
    for (int k = 0; k < N; k++) exp_regs[k] = 8'h00;
    check_regs("midrst");
    check("midrst_tx", 32'(i2c_data_tx), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    check("midrst_wr_stb", 32'(wr_stb), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // ptr restarted at 0: fifteen zero bytes, then the status byte.
    send_addr(8'h85);
    for (int i = 0; i < 15; i++) rd(8'h00);
    rd(8'h5A);

    repeat (4) cyc();
    check("wrq_drained", 32'(wrq.size()), 32'd0);
    check("rdq_drained", 32'(rdq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
